fir_mac_seq: RTL and testbench

FIR_MAC_SEQ -- requirements
Module: fir_mac_seq

---
 rtl/fir_pkg.sv | 26 ++
 rtl/sample_buf_ram.sv | 23 ++
 rtl/fir_mac_seq.sv | 142 ++++++++++++++
 tb/tb_fir_mac_seq.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types, widths and output limits for the sequential FIR MAC.
package fir_pkg;

    localparam int SAMPLE_W = 12;
    localparam int COEF_W   = 16;
    localparam int DATA_W   = 16;
    localparam int PROD_W   = DATA_W + COEF_W;

    localparam logic signed [DATA_W-1:0] Y_MAX = 16'sh7FFF;
    localparam logic signed [DATA_W-1:0] Y_MIN = 16'sh8000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MAC,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Offset-binary to two's complement: flip the MSB, then sign-extend.
    function automatic logic signed [DATA_W-1:0] to_signed(
        input logic [SAMPLE_W-1:0] s
    );
        return {{(DATA_W-SAMPLE_W+1){~s[SAMPLE_W-1]}}, s[SAMPLE_W-2:0]};
    endfunction

endpackage

// File: rtl/sample_buf_ram.sv
// Sample history buffer: one write port, one synchronous read port.
module sample_buf_ram #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/fir_mac_seq.sv
// Single-multiplier sequential FIR: one tap per cycle, saturated Q15 output.
module fir_mac_seq
    import fir_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int TAPS       = 64,
    parameter int OUT_SHIFT  = 15
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic [SAMPLE_W-1:0]   sample_in,
    input  logic                  sample_valid_in,
    output logic                  ready_out,
    output logic [ADDR_WIDTH-1:0] coef_addr_out,
    input  logic [COEF_W-1:0]     coef_in,
    output logic [DATA_W-1:0]     y_out,
    output logic                  y_valid_out,
    output logic                  overrun_out
);

    localparam int ACC_W = PROD_W + ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_TAP = ADDR_WIDTH'(TAPS - 1);
    localparam logic [ADDR_WIDTH:0]   FILL_MAX = (ADDR_WIDTH+1)'(TAPS);
    localparam logic signed [ACC_W-1:0] HI = ACC_W'(Y_MAX);
    localparam logic signed [ACC_W-1:0] LO = ACC_W'(Y_MIN);

    state_t state;

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] newest;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH:0]   fill;
    logic                  accept;
    logic                  rd_v;
    logic                  rd_mask;
    logic                  prod_v;
    logic signed [DATA_W-1:0] rd_data;
    logic signed [PROD_W-1:0] mul;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_sh;
    logic signed [DATA_W-1:0] y_sat;

    assign ready_out = (state == ST_IDLE);
    assign accept    = sample_valid_in && ready_out;
    assign rd_addr   = newest - coef_addr_out;
    assign mul       = rd_data * $signed(coef_in);
    assign acc_sh    = acc >>> OUT_SHIFT;

    always_comb begin
        if (acc_sh > HI) begin
            y_sat = Y_MAX;
        end else if (acc_sh < LO) begin
            y_sat = Y_MIN;
        end else begin
            y_sat = acc_sh[DATA_W-1:0];
        end
    end

    sample_buf_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_W)
    ) u_buf (
        .clk   (clk_in),
        .we    (accept),
        .waddr (wr_ptr),
        .wdata (to_signed(sample_in)),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state         <= ST_IDLE;
            coef_addr_out <= '0;
            wr_ptr        <= '0;
            newest        <= '0;
            fill          <= '0;
            rd_v          <= 1'b0;
            rd_mask       <= 1'b0;
            prod_v        <= 1'b0;
            prod          <= '0;
            acc           <= '0;
            y_out         <= '0;
            y_valid_out   <= 1'b0;
            overrun_out   <= 1'b0;
        end else begin
            y_valid_out <= 1'b0;
            // Read-stage tag: taps beyond the fill count contribute zero.
            rd_v    <= (state == ST_MAC);
            rd_mask <= ({1'b0, coef_addr_out} < fill);
            prod_v  <= rd_v;
            if (rd_v && rd_mask) begin
                prod <= mul;
            end else begin
                prod <= '0;
            end
            if (prod_v) begin
                acc <= acc + ACC_W'(prod);
            end
            if (sample_valid_in && !ready_out) begin
                overrun_out <= 1'b1;
            end
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state         <= ST_MAC;
                        newest        <= wr_ptr;
                        wr_ptr        <= wr_ptr + 1'b1;
                        acc           <= '0;
                        coef_addr_out <= '0;
                        if (fill != FILL_MAX) begin
                            fill <= fill + 1'b1;
                        end
                    end
                end
                ST_MAC: begin
                    if (coef_addr_out == LAST_TAP) begin
                        state         <= ST_DRAIN;
                        coef_addr_out <= '0;
                    end else begin
                        coef_addr_out <= coef_addr_out + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (!rd_v && !prod_v) begin
                        state       <= ST_DONE;
                        y_out       <= y_sat;
                        y_valid_out <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_seq.sv
// Directed bench for fir_mac_seq: three instances at different tap counts.
module tb_fir_mac_seq;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    logic [11:0] a_s, b_s, c_s;
    logic        a_v, b_v, c_v;
    logic        a_rdy, b_rdy, c_rdy;
    logic [7:0]  a_addr, b_addr;
    logic [3:0]  c_addr;
    logic [15:0] a_coef, b_coef, c_coef;
    logic [15:0] a_y, b_y, c_y;
    logic        a_yv, b_yv, c_yv;
    logic        a_ovr, b_ovr, c_ovr;

    logic [15:0] a_cm [256];
    logic [15:0] b_cm [256];
    logic [15:0] c_cm [16];

    always @(posedge clk) begin
        a_coef <= a_cm[a_addr];
        b_coef <= b_cm[b_addr];
        c_coef <= c_cm[c_addr];
    end

    fir_mac_seq #(.ADDR_WIDTH(8), .TAPS(4), .OUT_SHIFT(15)) dut_a (
        .clk_in(clk), .rst_n_in(rst_n), .sample_in(a_s),
        .sample_valid_in(a_v), .ready_out(a_rdy), .coef_addr_out(a_addr),
        .coef_in(a_coef), .y_out(a_y), .y_valid_out(a_yv),
        .overrun_out(a_ovr)
    );

    fir_mac_seq #(.ADDR_WIDTH(8), .TAPS(32), .OUT_SHIFT(15)) dut_b (
        .clk_in(clk), .rst_n_in(rst_n), .sample_in(b_s),
        .sample_valid_in(b_v), .ready_out(b_rdy), .coef_addr_out(b_addr),
        .coef_in(b_coef), .y_out(b_y), .y_valid_out(b_yv),
        .overrun_out(b_ovr)
    );

    fir_mac_seq #(.ADDR_WIDTH(4), .TAPS(16), .OUT_SHIFT(15)) dut_c (
        .clk_in(clk), .rst_n_in(rst_n), .sample_in(c_s),
        .sample_valid_in(c_v), .ready_out(c_rdy), .coef_addr_out(c_addr),
        .coef_in(c_coef), .y_out(c_y), .y_valid_out(c_yv),
        .overrun_out(c_ovr)
    );

    task automatic drive(input int sel, input logic [11:0] s, input logic v);
        case (sel)
            0: begin a_s = s; a_v = v; end
            1: begin b_s = s; b_v = v; end
            default: begin c_s = s; c_v = v; end
        endcase
    endtask

    task automatic peek(input int sel, output logic rdy, output logic yv,
                        output logic [15:0] y);
        case (sel)
            0: begin rdy = a_rdy; yv = a_yv; y = a_y; end
            1: begin rdy = b_rdy; yv = b_yv; y = b_y; end
            default: begin rdy = c_rdy; yv = c_yv; y = c_y; end
        endcase
    endtask

    // Offer one sample (optionally held a second cycle) and wait for y_valid.
    task automatic send(input int sel, input logic [11:0] s, input bit dbl,
                        output logic [15:0] y, output int lat);
        logic rdy, yv;
        logic [15:0] yo;
        lat = -1;
        y = 'x;
        @(negedge clk);
        for (int i = 0; i < 100; i++) begin
            peek(sel, rdy, yv, yo);
            if (rdy) break;
            @(negedge clk);
        end
        drive(sel, s, 1'b1);
        @(posedge clk);
        #1;
        if (!dbl) drive(sel, s, 1'b0);
        for (int n = 1; n <= 80; n++) begin
            @(posedge clk);
            #1;
            drive(sel, s, 1'b0);
            peek(sel, rdy, yv, yo);
            if (yv) begin
                lat = n;
                y = yo;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(0, 12'h0, 1'b0);
        drive(1, 12'h0, 1'b0);
        drive(2, 12'h0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_sum();
        logic [15:0] e [4];
        logic [15:0] y;
        int lat;
        e = '{16'd1023, 16'd2047, 16'd3070, 16'd4094};
        for (int k = 0; k < 256; k++) a_cm[k] = 16'h4000;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send(0, 12'hFFF, 1'b0, y, lat);
            checks++;
            if (y !== e[i]) begin
                fails++;
                $display("FAIL sum[%0d]: got %0d expected %0d", i, y, e[i]);
            end
            if (i == 0) begin
                checks++;
                if (lat != 7) begin
                    fails++;
                    $display("FAIL latency4: got %0d expected 7", lat);
                end
            end
        end
        checks++;
        if (a_addr !== 8'd0) begin
            fails++;
            $display("FAIL idle_addr: got %0d expected 0", a_addr);
        end
    endtask

    task automatic test_overrun();
        logic [15:0] y;
        int lat;
        do_reset();
        checks++;
        if (a_ovr !== 1'b0) begin
            fails++;
            $display("FAIL ovr_reset: got %0b expected 0", a_ovr);
        end
        send(0, 12'hFFF, 1'b1, y, lat);
        checks++;
        if (y !== 16'd1023) begin
            fails++;
            $display("FAIL ovr_y: got %0d expected 1023", y);
        end
        checks++;
        if (a_ovr !== 1'b1) begin
            fails++;
            $display("FAIL ovr_flag: got %0b expected 1", a_ovr);
        end
        send(0, 12'hFFF, 1'b0, y, lat);
        checks++;
        if (y !== 16'd2047) begin
            fails++;
            $display("FAIL ovr_next: got %0d expected 2047", y);
        end
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (a_y !== 16'd0) begin
            fails++;
            $display("FAIL rst_y: got %0d expected 0", a_y);
        end
        checks++;
        if (a_ovr !== 1'b0 || a_yv !== 1'b0) begin
            fails++;
            $display("FAIL rst_flags: got ovr=%0b yv=%0b expected 0 0",
                     a_ovr, a_yv);
        end
        checks++;
        if (a_rdy !== 1'b1 || a_addr !== 8'd0) begin
            fails++;
            $display("FAIL rst_rdy_addr: got rdy=%0b addr=%0d expected 1 0",
                     a_rdy, a_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_impulse();
        logic [15:0] e [4];
        logic [11:0] s [4];
        logic [15:0] y;
        int lat;
        e = '{16'd2046, 16'd1023, 16'd511, 16'd255};
        s = '{12'hFFF, 12'h800, 12'h800, 12'h800};
        a_cm[0] = 16'h7FFF;
        a_cm[1] = 16'h4000;
        a_cm[2] = 16'h2000;
        a_cm[3] = 16'h1000;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send(0, s[i], 1'b0, y, lat);
            checks++;
            if (y !== e[i]) begin
                fails++;
                $display("FAIL impulse[%0d]: got %0d expected %0d", i, y, e[i]);
            end
        end
    endtask

    task automatic test_abort();
        logic [15:0] y;
        int lat;
        bit seen;
        for (int k = 0; k < 256; k++) a_cm[k] = 16'h4000;
        do_reset();
        seen = 1'b0;
        @(negedge clk);
        drive(0, 12'hFFF, 1'b1);
        @(posedge clk);
        #1;
        drive(0, 12'hFFF, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
            if (a_yv) seen = 1'b1;
        end
        checks++;
        if (a_rdy !== 1'b0) begin
            fails++;
            $display("FAIL abort_busy: got rdy=%0b expected 0", a_rdy);
        end
        rst_n = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (a_yv) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            fails++;
            $display("FAIL abort_valid: got y_valid=1 expected 0");
        end
        @(negedge clk);
        rst_n = 1'b1;
        send(0, 12'hFFF, 1'b0, y, lat);
        checks++;
        if (y !== 16'd1023) begin
            fails++;
            $display("FAIL abort_after: got %0d expected 1023", y);
        end
    endtask

    task automatic test_saturate();
        logic [15:0] y;
        int lat;
        for (int k = 0; k < 256; k++) b_cm[k] = 16'h7FFF;
        do_reset();
        for (int i = 0; i < 32; i++) send(1, 12'hFFF, 1'b0, y, lat);
        checks++;
        if (y !== 16'h7FFF) begin
            fails++;
            $display("FAIL sat_hi: got %h expected 7fff", y);
        end
        checks++;
        if (lat != 35) begin
            fails++;
            $display("FAIL latency32: got %0d expected 35", lat);
        end
        for (int i = 0; i < 32; i++) send(1, 12'h000, 1'b0, y, lat);
        checks++;
        if (y !== 16'h8000) begin
            fails++;
            $display("FAIL sat_lo: got %h expected 8000", y);
        end
    endtask

    task automatic test_wrap();
        longint h [40];
        longint acc, sh, e;
        logic [11:0] s;
        logic [15:0] y;
        int lat;
        for (int k = 0; k < 16; k++) c_cm[k] = 16'(k * 2000 - 15000);
        do_reset();
        for (int i = 0; i < 40; i++) begin
            s = 12'((i * 373 + 91) % 4096);
            h[i] = longint'(s) - 2048;
            acc = 0;
            for (int k = 0; k < 16; k++) begin
                if (k <= i) acc += h[i-k] * longint'($signed(c_cm[k]));
            end
            sh = acc >>> 15;
            e = (sh > 32767) ? 32767 : ((sh < -32768) ? -32768 : sh);
            send(2, s, 1'b0, y, lat);
            checks++;
            if (y !== 16'(e)) begin
                fails++;
                $display("FAIL wrap[%0d]: got %0d expected %0d",
                         i, $signed(y), e);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 12'h0, 1'b0);
        drive(1, 12'h0, 1'b0);
        drive(2, 12'h0, 1'b0);
        test_sum();
        test_overrun();
        test_async_reset();
        test_impulse();
        test_abort();
        test_saturate();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
